// File: rtl/sbox_issue_sched.sv
// Issue scheduler for the shared masked, pipelined AES S-box: arbitrates two requesters,
// feeds fresh randomness and routes tagged results back. Option: SBOX_SCHED_FIXED_PRIO_EN.
module sbox_issue_sched #(
    parameter int SHARES  = 2,
    parameter int LATENCY = 5,
    parameter int TAGW    = 4,
    parameter int RNDW    = 9*SHARES*(SHARES-1) + 10*SHARES
) (
    input  logic                  ClkxCI,
    input  logic                  RstxRI,
    input  logic                  Req0ValidxSI,
    output logic                  Req0ReadyxSO,
    input  logic [8*SHARES-1:0]   Req0DataxDI,
    input  logic [TAGW-1:0]       Req0TagxDI,
    input  logic                  Req1ValidxSI,
    output logic                  Req1ReadyxSO,
    input  logic [8*SHARES-1:0]   Req1DataxDI,
    input  logic [TAGW-1:0]       Req1TagxDI,
    output logic                  Rsp0ValidxSO,
    output logic [8*SHARES-1:0]   Rsp0DataxDO,
    output logic [TAGW-1:0]       Rsp0TagxDO,
    output logic                  Rsp1ValidxSO,
    output logic [8*SHARES-1:0]   Rsp1DataxDO,
    output logic [TAGW-1:0]       Rsp1TagxDO,
    input  logic [RNDW-1:0]       RndxDI,
    input  logic                  RndValidxSI,
    output logic                  RndReadyxSO,
    output logic [8*SHARES-1:0]   SboxXxDO,
    output logic [RNDW-1:0]       SboxRndxDO,
    input  logic [8*SHARES-1:0]   SboxQxDI,
    input  logic                  FlushxSI,
    output logic                  BusyxSO,
    output logic                  RndErrxSO
);

    logic [LATENCY:0] LineValidxDP;
    logic [LATENCY:0] LineIdxDP;
    logic [TAGW-1:0]  LineTagxDP [LATENCY+1];
    logic [LATENCY:0] LineValidNxtxS;

    logic AnyValidxS;
    logic IssuexS;
    logic GntIdxS;
    logic StarvexS;
    logic KillxS;

    assign AnyValidxS = |LineValidxDP;
    assign IssuexS    = (Req0ValidxSI | Req1ValidxSI) & RndValidxSI & ~FlushxSI
                        & ~RndErrxSO & ~RstxRI;

`ifdef SBOX_SCHED_FIXED_PRIO_EN
    assign GntIdxS = Req1ValidxSI;
`else
    logic LastGntxDP;
    assign GntIdxS = (Req0ValidxSI & Req1ValidxSI) ? ~LastGntxDP : Req1ValidxSI;
`endif

    assign Req0ReadyxSO = IssuexS & ~GntIdxS;
    assign Req1ReadyxSO = IssuexS &  GntIdxS;

    // Every occupied S-box stage needs fresh masks, so a missing word with ops in flight
    // leaves them without valid randomness and they must be discarded.
    assign RndReadyxSO = IssuexS | AnyValidxS;
    assign StarvexS    = AnyValidxS & ~RndValidxSI;
    assign KillxS      = FlushxSI | StarvexS;

    assign LineValidNxtxS = {LineValidxDP[LATENCY-1:0], IssuexS} & {(LATENCY+1){~KillxS}};

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            LineValidxDP <= '0;
            LineIdxDP    <= '0;
            for (int k = 0; k <= LATENCY; k++) LineTagxDP[k] <= '0;
            SboxXxDO     <= '0;
            SboxRndxDO   <= '0;
            Rsp0ValidxSO <= 1'b0;
            Rsp0DataxDO  <= '0;
            Rsp0TagxDO   <= '0;
            Rsp1ValidxSO <= 1'b0;
            Rsp1DataxDO  <= '0;
            Rsp1TagxDO   <= '0;
            BusyxSO      <= 1'b0;
            RndErrxSO    <= 1'b0;
`ifndef SBOX_SCHED_FIXED_PRIO_EN
            LastGntxDP   <= 1'b1;
`endif
        end else begin
            SboxXxDO   <= IssuexS ? (GntIdxS ? Req1DataxDI : Req0DataxDI) : '0;
            SboxRndxDO <= (RndValidxSI & RndReadyxSO) ? RndxDI : '0;

            LineValidxDP  <= LineValidNxtxS;
            LineIdxDP     <= {LineIdxDP[LATENCY-1:0], GntIdxS};
            LineTagxDP[0] <= GntIdxS ? Req1TagxDI : Req0TagxDI;
            for (int k = 1; k <= LATENCY; k++) LineTagxDP[k] <= LineTagxDP[k-1];
            BusyxSO       <= |LineValidNxtxS;

            // Last stage lines up with SboxQxDI; a killed op never responds.
            Rsp0ValidxSO <= 1'b0;
            Rsp0DataxDO  <= '0;
            Rsp0TagxDO   <= '0;
            Rsp1ValidxSO <= 1'b0;
            Rsp1DataxDO  <= '0;
            Rsp1TagxDO   <= '0;
            if (LineValidxDP[LATENCY] & ~KillxS) begin
                if (LineIdxDP[LATENCY]) begin
                    Rsp1ValidxSO <= 1'b1;
                    Rsp1DataxDO  <= SboxQxDI;
                    Rsp1TagxDO   <= LineTagxDP[LATENCY];
                end else begin
                    Rsp0ValidxSO <= 1'b1;
                    Rsp0DataxDO  <= SboxQxDI;
                    Rsp0TagxDO   <= LineTagxDP[LATENCY];
                end
            end

            if (FlushxSI)      RndErrxSO <= 1'b0;
            else if (StarvexS) RndErrxSO <= 1'b1;

`ifndef SBOX_SCHED_FIXED_PRIO_EN
            if (IssuexS) LastGntxDP <= GntIdxS;
`endif
        end
    end

endmodule

// File: tb/tb_sbox_issue_sched.sv
// Scoreboard bench for sbox_issue_sched with a behavioural 5-stage masked S-box model.
module tb_sbox_issue_sched;
    localparam int SHARES = 2, LATENCY = 5, TAGW = 4, RNDW = 38, DW = 16;

    logic ClkxCI = 1'b0;
    logic RstxRI = 1'b1;
    logic Req0ValidxSI = 0, Req1ValidxSI = 0, Req0ReadyxSO, Req1ReadyxSO;
    logic [DW-1:0] Req0DataxDI = '0, Req1DataxDI = '0;
    logic [TAGW-1:0] Req0TagxDI = '0, Req1TagxDI = '0;
    logic Rsp0ValidxSO, Rsp1ValidxSO;
    logic [DW-1:0] Rsp0DataxDO, Rsp1DataxDO;
    logic [TAGW-1:0] Rsp0TagxDO, Rsp1TagxDO;
    logic [RNDW-1:0] RndxDI = '0;
    logic RndValidxSI = 0, RndReadyxSO;
    logic [DW-1:0] SboxXxDO, SboxQxDI;
    logic [RNDW-1:0] SboxRndxDO;
    logic FlushxSI = 0, BusyxSO, RndErrxSO;

    sbox_issue_sched #(.SHARES(SHARES), .LATENCY(LATENCY), .TAGW(TAGW), .RNDW(RNDW)) dut (
        .ClkxCI(ClkxCI), .RstxRI(RstxRI),
        .Req0ValidxSI(Req0ValidxSI), .Req0ReadyxSO(Req0ReadyxSO),
        .Req0DataxDI(Req0DataxDI), .Req0TagxDI(Req0TagxDI),
        .Req1ValidxSI(Req1ValidxSI), .Req1ReadyxSO(Req1ReadyxSO),
        .Req1DataxDI(Req1DataxDI), .Req1TagxDI(Req1TagxDI),
        .Rsp0ValidxSO(Rsp0ValidxSO), .Rsp0DataxDO(Rsp0DataxDO), .Rsp0TagxDO(Rsp0TagxDO),
        .Rsp1ValidxSO(Rsp1ValidxSO), .Rsp1DataxDO(Rsp1DataxDO), .Rsp1TagxDO(Rsp1TagxDO),
        .RndxDI(RndxDI), .RndValidxSI(RndValidxSI), .RndReadyxSO(RndReadyxSO),
        .SboxXxDO(SboxXxDO), .SboxRndxDO(SboxRndxDO), .SboxQxDI(SboxQxDI),
        .FlushxSI(FlushxSI), .BusyxSO(BusyxSO), .RndErrxSO(RndErrxSO)
    );

    always #5 ClkxCI = ~ClkxCI;

    int cyc = 0;
    always @(posedge ClkxCI) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] aesSbox(input logic [7:0] x);
        logic [7:0] r = x;
        logic [7:0] s;
        for (int i = 1; i < 254; i++) r = gmul(r, x);
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    // Behavioural masked S-box: remasks the result with randomness from its input cycle.
    logic [DW-1:0] pipeQ [LATENCY];
    always @(posedge ClkxCI) begin
        logic [7:0] m;
        m = SboxRndxDO[7:0];
        pipeQ[0] <= {m, aesSbox(SboxXxDO[7:0] ^ SboxXxDO[15:8]) ^ m};
        for (int k = 1; k < LATENCY; k++) pipeQ[k] <= pipeQ[k-1];
    end
    assign SboxQxDI = pipeQ[LATENCY-1];

    typedef struct {
        bit         port;
        logic [3:0] tag;
        logic [7:0] val;
        int         at;
    } exp_t;
    exp_t expQ [$];

    always @(negedge ClkxCI) begin
        exp_t e;
        if (Rsp0ValidxSO || Rsp1ValidxSO) begin
            if (Rsp0ValidxSO && Rsp1ValidxSO) chk("rsp_both_valid", 1, 0);
            else if (expQ.size() == 0) chk("rsp_unexpected", Rsp1ValidxSO ? 1 : 0, 9);
            else begin
                e = expQ.pop_front();
                chk("rsp_port", Rsp1ValidxSO ? 1 : 0, e.port);
                chk("rsp_cycle", cyc, e.at);
                chk("rsp_tag", Rsp1ValidxSO ? Rsp1TagxDO : Rsp0TagxDO, e.tag);
                chk("rsp_value", Rsp1ValidxSO ? (Rsp1DataxDO[7:0] ^ Rsp1DataxDO[15:8])
                                              : (Rsp0DataxDO[7:0] ^ Rsp0DataxDO[15:8]), e.val);
            end
        end
        if (!Rsp0ValidxSO) chk("rsp0_data_idle", Rsp0DataxDO, 0);
        if (!Rsp1ValidxSO) chk("rsp1_data_idle", Rsp1DataxDO, 0);
    end

    task automatic cycleStart();
        logic [63:0] r;
        @(posedge ClkxCI);
        #1;
        r = {$urandom(), $urandom()};
        RndxDI = r[RNDW-1:0];
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expectRsp(input bit port, input logic [3:0] tag, input logic [7:0] val);
        exp_t e;
        e.port = port; e.tag = tag; e.val = val; e.at = cyc + LATENCY + 2;
        expQ.push_back(e);
    endtask

    task automatic idleReqs();
        Req0ValidxSI = 0; Req1ValidxSI = 0; FlushxSI = 0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cycleStart(); idleReqs();
        end
    endtask

    task automatic doReset();
        cycleStart(); idleReqs(); RstxRI = 1;
        cycleStart(); RstxRI = 0;
    endtask

    task automatic checkAllZero(input string pfx);
        chk({pfx, "_ready0"}, Req0ReadyxSO, 0);
        chk({pfx, "_ready1"}, Req1ReadyxSO, 0);
        chk({pfx, "_rsp0valid"}, Rsp0ValidxSO, 0);
        chk({pfx, "_rsp1valid"}, Rsp1ValidxSO, 0);
        chk({pfx, "_rndready"}, RndReadyxSO, 0);
        chk({pfx, "_sboxx"}, SboxXxDO, 0);
        chk({pfx, "_sboxrnd"}, SboxRndxDO, 0);
        chk({pfx, "_busy"}, BusyxSO, 0);
        chk({pfx, "_rnderr"}, RndErrxSO, 0);
    endtask

    logic [RNDW-1:0] rndKeep;
    bit g;

    initial begin
        RstxRI = 1;
        cycleStart();
        cycleStart(); RstxRI = 0; settle();
        checkAllZero("reset");

        // Single Req0 byte 0x00
        cycleStart(); RndValidxSI = 1;
        Req0ValidxSI = 1; Req0DataxDI = 16'h0000; Req0TagxDI = 4'h5;
        rndKeep = 38'h2A_5A5A_A5A5; RndxDI = rndKeep; settle();
        chk("t1_ready0", Req0ReadyxSO, 1);
        chk("t1_ready1", Req1ReadyxSO, 0);
        chk("t1_rndready", RndReadyxSO, 1);
        expectRsp(0, 4'h5, 8'h63);
        cycleStart(); idleReqs(); settle();
        chk("t1_sboxrnd", SboxRndxDO, rndKeep);
        chk("t1_busy", BusyxSO, 1);
        drain(10);

        // Both requesters held valid for 8 cycles
        doReset();
        for (int i = 0; i < 8; i++) begin
            cycleStart();
            Req0ValidxSI = 1; Req0DataxDI = {8'hC3 ^ 8'h53, 8'hC3}; Req0TagxDI = 4'hA;
            Req1ValidxSI = 1; Req1DataxDI = {8'h76, 8'h77};         Req1TagxDI = 4'h3;
            settle();
`ifdef SBOX_SCHED_FIXED_PRIO_EN
            g = 1'b1;
`else
            g = (i % 2) == 1;
`endif
            chk("t2_ready0", Req0ReadyxSO, !g);
            chk("t2_ready1", Req1ReadyxSO, g);
            if (g) expectRsp(1, 4'h3, 8'h7C);
            else   expectRsp(0, 4'hA, 8'hED);
        end
        drain(12);

        // Randomness unavailable with an empty pipe
        for (int i = 0; i < 3; i++) begin
            cycleStart(); RndValidxSI = 0;
            Req1ValidxSI = 1; Req1DataxDI = {8'h11 ^ 8'h53, 8'h11}; Req1TagxDI = 4'h6;
            settle();
            chk("t3_ready1_wait", Req1ReadyxSO, 0);
            chk("t3_rndready_wait", RndReadyxSO, 0);
            chk("t3_rnderr_wait", RndErrxSO, 0);
        end
        cycleStart(); RndValidxSI = 1; settle();
        chk("t3_ready1_go", Req1ReadyxSO, 1);
        expectRsp(1, 4'h6, 8'hED);
        drain(10);

        // Starvation with three ops in flight, recovery by flush
        for (int i = 0; i < 3; i++) begin
            cycleStart(); Req0ValidxSI = 1; Req0DataxDI = {8'h80, 8'h81}; Req0TagxDI = 4'(i + 1);
            settle();
            chk("t4_ready0_fill", Req0ReadyxSO, 1);
        end
        cycleStart(); idleReqs(); RndValidxSI = 0; settle();
        chk("t4_rndready_starve", RndReadyxSO, 1);
        cycleStart(); RndValidxSI = 1; Req0ValidxSI = 1; Req0TagxDI = 4'h4; settle();
        chk("t4_rnderr_set", RndErrxSO, 1);
        chk("t4_busy_cleared", BusyxSO, 0);
        chk("t4_ready0_blocked", Req0ReadyxSO, 0);
        cycleStart(); settle();
        chk("t4_ready0_blocked2", Req0ReadyxSO, 0);
        cycleStart(); FlushxSI = 1; settle();
        chk("t4_ready0_flush", Req0ReadyxSO, 0);
        cycleStart(); FlushxSI = 0; settle();
        chk("t4_rnderr_clear", RndErrxSO, 0);
        chk("t4_ready0_resume", Req0ReadyxSO, 1);
        expectRsp(0, 4'h4, 8'h7C);
        drain(12);

        // Flush two cycles after two issues
        for (int i = 0; i < 2; i++) begin
            cycleStart(); Req1ValidxSI = 1; Req1DataxDI = {8'h00, 8'h53}; Req1TagxDI = 4'(7 + i);
            settle();
            chk("t5_ready1", Req1ReadyxSO, 1);
        end
        cycleStart(); idleReqs();
        cycleStart(); FlushxSI = 1; settle();
        chk("t5_busy_before", BusyxSO, 1);
        cycleStart(); FlushxSI = 0; settle();
        chk("t5_busy_after", BusyxSO, 0);
        drain(10);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            cycleStart();
            Req0ValidxSI = 1; Req0DataxDI = 16'h1234; Req0TagxDI = 4'h1;
            Req1ValidxSI = 1; Req1DataxDI = 16'h5678; Req1TagxDI = 4'h2;
        end
        cycleStart(); idleReqs(); RstxRI = 1;
        cycleStart(); RstxRI = 0; settle();
        checkAllZero("t6");
        cycleStart();
        Req0ValidxSI = 1; Req0DataxDI = {8'h00, 8'h53}; Req0TagxDI = 4'hB;
        Req1ValidxSI = 1; Req1DataxDI = {8'h00, 8'h01}; Req1TagxDI = 4'hD;
        settle();
`ifdef SBOX_SCHED_FIXED_PRIO_EN
        chk("t6_first_conflict", Req1ReadyxSO, 1);
        expectRsp(1, 4'hD, 8'h7C);
`else
        chk("t6_first_conflict", Req0ReadyxSO, 1);
        expectRsp(0, 4'hB, 8'hED);
`endif
        drain(12);

        chk("scoreboard_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
